// File: rtl/wb_downsize_seq.sv
// wb_downsize_seq: sequencing Wishbone width converter, 32-bit master port to
// an 8- or 16-bit slave port. Each master access becomes one classic slave
// beat per active lane, lowest address first (big-endian, sel[3] = offset 0).
// Read lanes are gathered into one word and returned with a single
// ack/err/rty.
// Optional build macro WB_DOWNSIZE_TIMEOUT_EN adds a per-beat watchdog that
// turns a silent slave into a master error after TIMEOUT cycles.
module wb_downsize_seq #(
  parameter int aw      = 32,
  parameter int sdw     = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic [aw-1:0]     wbm_adr_i,
  input  logic [31:0]       wbm_dat_i,
  input  logic [3:0]        wbm_sel_i,
  input  logic              wbm_we_i,
  input  logic              wbm_cyc_i,
  input  logic              wbm_stb_i,
  input  logic [2:0]        wbm_cti_i,
  input  logic [1:0]        wbm_bte_i,
  output logic [31:0]       wbm_dat_o,
  output logic              wbm_ack_o,
  output logic              wbm_err_o,
  output logic              wbm_rty_o,
  output logic [aw-1:0]     wbs_adr_o,
  output logic [sdw-1:0]    wbs_dat_o,
  output logic [sdw/8-1:0]  wbs_sel_o,
  output logic              wbs_we_o,
  output logic              wbs_cyc_o,
  output logic              wbs_stb_o,
  output logic [2:0]        wbs_cti_o,
  output logic [1:0]        wbs_bte_o,
  input  logic [sdw-1:0]    wbs_dat_i,
  input  logic              wbs_ack_i,
  input  logic              wbs_err_i,
  input  logic              wbs_rty_i
);
  localparam int nl  = 32 / sdw;          // lanes per master word
  localparam int bpl = sdw / 8;           // bytes per lane
  localparam int lw  = (nl > 2) ? 2 : 1;  // lane index width

  typedef enum logic [2:0] {IDLE, XFER, DONE, ERR, RTY} state_t;

  state_t          state_reg, state_next;
  logic [aw-3:0]   adr_reg;
  logic            we_reg;
  logic [31:0]     wdat_reg;
  logic [31:0]     rdat_reg;
  logic [nl-1:0]   pend_reg;
  logic [nl-1:0]   req_mask;
  logic [nl-1:0]   lane_hot;
  logic [nl-1:0]   pend_left;
  logic [lw-1:0]   lane;
  logic [1:0]      lane_off;
  logic            xfer;
  logic            accept;
  logic            beat_ok;
  logic            timeout;

  // Lane mask: one bit per slave-width lane touched by the byte selects
  generate
    if (sdw == 16) begin : g_mask16
      assign req_mask = {|wbm_sel_i[3:2], |wbm_sel_i[1:0]};
    end else begin : g_mask8
      assign req_mask = wbm_sel_i;
    end
  endgenerate

  assign xfer    = (state_reg == XFER);
  assign accept  = wbm_cyc_i & wbm_stb_i;
  assign beat_ok = xfer & wbm_cyc_i & wbs_ack_i & ~wbs_err_i & ~wbs_rty_i;

  // Active lane is the highest pending bit (lowest byte address)
  always_comb begin
    lane = '0;
    for (int i = 0; i < nl; i++) begin
      if (pend_reg[i]) lane = lw'(i);
    end
    lane_hot       = '0;
    lane_hot[lane] = 1'b1;
    lane_off       = 2'((nl - 1 - int'(lane)) * bpl);
    pend_left      = pend_reg & ~lane_hot;
  end

`ifdef WB_DOWNSIZE_TIMEOUT_EN
  localparam int tw = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [tw-1:0] tcnt_reg;

  // Watchdog: counts silent cycles of the current beat, restarts per beat
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)
      tcnt_reg <= '0;
    else if (!xfer || wbs_ack_i || wbs_err_i || wbs_rty_i)
      tcnt_reg <= '0;
    else
      tcnt_reg <= tcnt_reg + 1'b1;
  end

  assign timeout = (tcnt_reg == tw'(TIMEOUT));
`else
  assign timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_reg <= IDLE;
    else            state_reg <= state_next;
  end

  // Next state; a dropped master cycle outranks any slave response
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = (req_mask == '0) ? DONE : XFER;
      XFER: begin
        if (!wbm_cyc_i)            state_next = IDLE;
        else if (wbs_err_i)        state_next = ERR;
        else if (wbs_rty_i)        state_next = RTY;
        else if (wbs_ack_i) begin
          if (pend_left == '0)     state_next = DONE;
        end
        else if (timeout)          state_next = ERR;
      end
      default:                     state_next = IDLE;
    endcase
  end

  // Request latch, lane bookkeeping and read-data gathering
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      adr_reg  <= '0;
      we_reg   <= 1'b0;
      wdat_reg <= '0;
      rdat_reg <= '0;
      pend_reg <= '0;
    end else if (state_reg == IDLE && accept) begin
      adr_reg  <= wbm_adr_i[aw-1:2];
      we_reg   <= wbm_we_i;
      wdat_reg <= wbm_dat_i;
      rdat_reg <= '0;
      pend_reg <= req_mask;
    end else if (beat_ok) begin
      rdat_reg[int'(lane)*sdw +: sdw] <= wbs_dat_i;
      pend_reg <= pend_left;
    end else if (xfer && (!wbm_cyc_i || wbs_err_i || wbs_rty_i || timeout)) begin
      pend_reg <= '0;
    end
  end

  assign wbs_cyc_o = xfer;
  assign wbs_stb_o = xfer;
  assign wbs_sel_o = {bpl{xfer}};
  assign wbs_adr_o = xfer ? {adr_reg, lane_off} : '0;
  assign wbs_dat_o = xfer ? wdat_reg[int'(lane)*sdw +: sdw] : '0;
  assign wbs_we_o  = we_reg;
  assign wbs_cti_o = 3'b000;
  assign wbs_bte_o = 2'b00;

  assign wbm_dat_o = rdat_reg;
  assign wbm_ack_o = (state_reg == DONE);
  assign wbm_err_o = (state_reg == ERR);
  assign wbm_rty_o = (state_reg == RTY);

  // Burst qualifiers and the word-offset address bits are intentionally unused
  logic unused_ok;
  assign unused_ok = ^{wbm_cti_i, wbm_bte_i, wbm_adr_i[1:0], 32'(TIMEOUT)};
endmodule

// File: tb/tb_wb_downsize_seq.sv
// Bench for wb_downsize_seq: one 8-bit and one 16-bit instance, each behind a
// behavioural slave with a byte memory, random wait states and injectable
// err/rty. Expectations come from byte-address arithmetic on the request.
module tb_wb_downsize_seq;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] m_adr, m_dat;
  logic [3:0]  m_sel;
  logic        m_we;
  logic        m_cyc[2], m_stb[2];
  logic [2:0]  m_cti;
  logic [1:0]  m_bte;
  logic [31:0] m_rd[2];
  logic        m_ack[2], m_err[2], m_rty[2];

  logic [31:0] s_adr[2];
  logic [7:0]  s_dato8;
  logic [15:0] s_dato16;
  logic [0:0]  s_sel8;
  logic [1:0]  s_sel16;
  logic        s_we[2], s_cyc[2], s_stb[2];
  logic [2:0]  s_cti[2];
  logic [1:0]  s_bte[2];
  logic [15:0] s_dati[2];
  logic        s_ack[2], s_err[2], s_rty[2];
  logic [15:0] s_dato[2];
  assign s_dato[0] = {8'h00, s_dato8};
  assign s_dato[1] = s_dato16;

  logic [7:0]  smem[2][256];
  int          mode[2], ack_pct[2], err_beat[2], rty_beat[2], base_n[2];
  int          lg_n[2] = '{0, 0};
  logic [31:0] lg_adr[2][64];
  logic [15:0] lg_dat[2][64];
  logic        lg_we[2][64];

  int          total, bad;
  int          got_kind, got_lat;
  logic [31:0] got_rd;

  wb_downsize_seq #(.aw(32), .sdw(8), .TIMEOUT(255)) dut8 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_sel_i(m_sel), .wbm_we_i(m_we),
    .wbm_cyc_i(m_cyc[0]), .wbm_stb_i(m_stb[0]), .wbm_cti_i(m_cti), .wbm_bte_i(m_bte),
    .wbm_dat_o(m_rd[0]), .wbm_ack_o(m_ack[0]), .wbm_err_o(m_err[0]), .wbm_rty_o(m_rty[0]),
    .wbs_adr_o(s_adr[0]), .wbs_dat_o(s_dato8), .wbs_sel_o(s_sel8), .wbs_we_o(s_we[0]),
    .wbs_cyc_o(s_cyc[0]), .wbs_stb_o(s_stb[0]), .wbs_cti_o(s_cti[0]), .wbs_bte_o(s_bte[0]),
    .wbs_dat_i(s_dati[0][7:0]), .wbs_ack_i(s_ack[0]), .wbs_err_i(s_err[0]), .wbs_rty_i(s_rty[0])
  );

  wb_downsize_seq #(.aw(32), .sdw(16), .TIMEOUT(255)) dut16 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_sel_i(m_sel), .wbm_we_i(m_we),
    .wbm_cyc_i(m_cyc[1]), .wbm_stb_i(m_stb[1]), .wbm_cti_i(m_cti), .wbm_bte_i(m_bte),
    .wbm_dat_o(m_rd[1]), .wbm_ack_o(m_ack[1]), .wbm_err_o(m_err[1]), .wbm_rty_o(m_rty[1]),
    .wbs_adr_o(s_adr[1]), .wbs_dat_o(s_dato16), .wbs_sel_o(s_sel16), .wbs_we_o(s_we[1]),
    .wbs_cyc_o(s_cyc[1]), .wbs_stb_o(s_stb[1]), .wbs_cti_o(s_cti[1]), .wbs_bte_o(s_bte[1]),
    .wbs_dat_i(s_dati[1]), .wbs_ack_i(s_ack[1]), .wbs_err_i(s_err[1]), .wbs_rty_i(s_rty[1])
  );

  // Behavioural slaves: decide the response of each beat on the falling edge
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      s_ack[d]  <= 1'b0;
      s_err[d]  <= 1'b0;
      s_rty[d]  <= 1'b0;
      s_dati[d] <= 16'h0;
      if (rst_n && s_cyc[d] && s_stb[d] && mode[d] == 0) begin
        if ((lg_n[d] - base_n[d]) == err_beat[d] ||
            (lg_n[d] - base_n[d]) == rty_beat[d] ||
            $urandom_range(99) < ack_pct[d]) begin
          s_ack[d] <= 1'b1;
          s_err[d] <= ((lg_n[d] - base_n[d]) == err_beat[d]);
          s_rty[d] <= ((lg_n[d] - base_n[d]) == err_beat[d]) ||
                      ((lg_n[d] - base_n[d]) == rty_beat[d]);
          if (d == 0) s_dati[d] <= {8'h00, smem[0][s_adr[d][7:0]]};
          else        s_dati[d] <= {smem[1][s_adr[d][7:0]], smem[1][s_adr[d][7:0] + 8'd1]};
          lg_adr[d][lg_n[d] % 64] <= s_adr[d];
          lg_dat[d][lg_n[d] % 64] <= s_dato[d];
          lg_we[d][lg_n[d] % 64]  <= s_we[d];
          lg_n[d] <= lg_n[d] + 1;
        end
      end
    end
  end

  // Drive one master request and wait (bounded) for its termination
  task automatic run_txn(input int d, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic we);
    int i;
    @(negedge clk);
    base_n[d] = lg_n[d];
    m_adr = adr; m_dat = dat; m_sel = sel; m_we = we;
    m_cyc[d] = 1'b1; m_stb[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    got_kind = 0;
    i = 0;
    while (got_kind == 0 && i < 300) begin
      if (m_ack[d])      got_kind = 1;
      else if (m_err[d]) got_kind = 2;
      else if (m_rty[d]) got_kind = 3;
      else begin
        @(negedge clk);
        i++;
      end
    end
    got_lat = i + 1;
    got_rd  = m_rd[d];
    m_cyc[d] = 1'b0; m_stb[d] = 1'b0;
    $display("txn dut%0d adr=%h sel=%b we=%0d -> kind=%0d lat=%0d rd=%h beats=%0d",
             d, adr, sel, we, got_kind, got_lat, got_rd, lg_n[d] - base_n[d]);
  endtask

  task automatic defaults();
    for (int d = 0; d < 2; d++) begin
      mode[d] = 0; ack_pct[d] = 100; err_beat[d] = 99; rty_beat[d] = 99;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({s_cyc[d], s_stb[d], s_we[d], m_ack[d], m_err[d], m_rty[d]} !== 6'b0 ||
          s_adr[d] !== 32'h0 || s_dato[d] !== 16'h0 || m_rd[d] !== 32'h0 ||
          s_cti[d] !== 3'b0 || s_bte[d] !== 2'b0) begin
        bad++;
        $display("FAIL reset_outputs dut%0d: cyc=%b stb=%b we=%b adr=%h dat=%h rd=%h ack=%b err=%b rty=%b want all 0",
                 d, s_cyc[d], s_stb[d], s_we[d], s_adr[d], s_dato[d], m_rd[d], m_ack[d], m_err[d], m_rty[d]);
      end
    end
    total++;
    if (s_sel8 !== 1'b0 || s_sel16 !== 2'b0) begin
      bad++;
      $display("FAIL reset_sel: got %b/%b want 0/0", s_sel8, s_sel16);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read_full8();
    smem[0][8'h00] = 8'h11; smem[0][8'h01] = 8'h22;
    smem[0][8'h02] = 8'h33; smem[0][8'h03] = 8'h44;
    run_txn(0, 32'h0000_0100, 32'h0, 4'b1111, 1'b0);
    total++; if (got_kind !== 1) begin bad++; $display("FAIL rd8_kind: got %0d want 1", got_kind); end
    total++; if (got_lat !== 5) begin bad++; $display("FAIL rd8_latency: got %0d want 5", got_lat); end
    total++; if (got_rd !== 32'h11223344) begin bad++; $display("FAIL rd8_data: got %h want 11223344", got_rd); end
    total++; if (lg_n[0] - base_n[0] !== 4) begin bad++; $display("FAIL rd8_beats: got %0d want 4", lg_n[0] - base_n[0]); end
    for (int j = 0; j < 4; j++) begin
      total++;
      if (lg_adr[0][(base_n[0] + j) % 64] !== 32'h100 + j) begin
        bad++;
        $display("FAIL rd8_adr%0d: got %h want %h", j, lg_adr[0][(base_n[0] + j) % 64], 32'h100 + j);
      end
    end
  endtask

  task automatic test_write_partial8();
    run_txn(0, 32'h0000_0200, 32'hAABBCCDD, 4'b0011, 1'b1);
    total++; if (got_kind !== 1) begin bad++; $display("FAIL wr8_kind: got %0d want 1", got_kind); end
    total++; if (got_lat !== 3) begin bad++; $display("FAIL wr8_latency: got %0d want 3", got_lat); end
    total++; if (lg_n[0] - base_n[0] !== 2) begin bad++; $display("FAIL wr8_beats: got %0d want 2", lg_n[0] - base_n[0]); end
    total++;
    if (lg_adr[0][base_n[0] % 64] !== 32'h202 || lg_dat[0][base_n[0] % 64] !== 16'h00CC ||
        lg_we[0][base_n[0] % 64] !== 1'b1) begin
      bad++;
      $display("FAIL wr8_beat0: got adr=%h dat=%h we=%b want 202/00cc/1",
               lg_adr[0][base_n[0] % 64], lg_dat[0][base_n[0] % 64], lg_we[0][base_n[0] % 64]);
    end
    total++;
    if (lg_adr[0][(base_n[0] + 1) % 64] !== 32'h203 || lg_dat[0][(base_n[0] + 1) % 64] !== 16'h00DD) begin
      bad++;
      $display("FAIL wr8_beat1: got adr=%h dat=%h want 203/00dd",
               lg_adr[0][(base_n[0] + 1) % 64], lg_dat[0][(base_n[0] + 1) % 64]);
    end
  endtask

  task automatic test_read_sparse16();
    smem[1][8'h00] = 8'hA1; smem[1][8'h01] = 8'hB2;
    smem[1][8'h02] = 8'hC3; smem[1][8'h03] = 8'hD4;
    run_txn(1, 32'h0000_0300, 32'h0, 4'b1001, 1'b0);
    total++; if (got_kind !== 1) begin bad++; $display("FAIL rd16_kind: got %0d want 1", got_kind); end
    total++; if (got_lat !== 3) begin bad++; $display("FAIL rd16_latency: got %0d want 3", got_lat); end
    total++; if (got_rd !== 32'hA1B2C3D4) begin bad++; $display("FAIL rd16_data: got %h want a1b2c3d4", got_rd); end
    total++;
    if (lg_n[1] - base_n[1] !== 2 || lg_adr[1][base_n[1] % 64] !== 32'h300 ||
        lg_adr[1][(base_n[1] + 1) % 64] !== 32'h302) begin
      bad++;
      $display("FAIL rd16_beats: got n=%0d adr %h,%h want 2 beats at 300,302", lg_n[1] - base_n[1],
               lg_adr[1][base_n[1] % 64], lg_adr[1][(base_n[1] + 1) % 64]);
    end
  endtask

  task automatic test_err8();
    int n_after;
    err_beat[0] = 1;
    run_txn(0, 32'h0000_0400, 32'h0, 4'b1111, 1'b0);
    total++; if (got_kind !== 2) begin bad++; $display("FAIL err8_kind: got %0d want 2", got_kind); end
    total++; if (got_lat !== 3) begin bad++; $display("FAIL err8_latency: got %0d want 3", got_lat); end
    n_after = lg_n[0];
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (m_err[0] || m_ack[0] || s_cyc[0]) begin
        bad++;
        $display("FAIL err8_quiet%0d: got err=%b ack=%b cyc=%b want 0", k, m_err[0], m_ack[0], s_cyc[0]);
      end
    end
    total++;
    if (lg_n[0] - base_n[0] !== 2 || lg_n[0] !== n_after) begin
      bad++;
      $display("FAIL err8_beats: got %0d want 2", lg_n[0] - base_n[0]);
    end
    defaults();
  endtask

  task automatic test_priority();
    err_beat[1] = 0; rty_beat[1] = 0;
    run_txn(1, 32'h0000_0500, 32'h0, 4'b1111, 1'b0);
    total++; if (got_kind !== 2) begin bad++; $display("FAIL prio_err_over_rty: got %0d want 2", got_kind); end
    defaults();
    rty_beat[1] = 1;
    run_txn(1, 32'h0000_0504, 32'h0, 4'b1111, 1'b0);
    total++; if (got_kind !== 3) begin bad++; $display("FAIL prio_rty_over_ack: got %0d want 3", got_kind); end
    total++; if (lg_n[1] - base_n[1] !== 2) begin bad++; $display("FAIL rty_beats: got %0d want 2", lg_n[1] - base_n[1]); end
    defaults();
  endtask

  task automatic test_reset_mid_xfer();
    mode[0] = 1;
    @(negedge clk);
    m_adr = 32'h600; m_sel = 4'hF; m_we = 1'b1; m_dat = 32'h12345678;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    @(posedge clk); @(negedge clk); @(negedge clk);
    total++; if (s_cyc[0] !== 1'b1) begin bad++; $display("FAIL rstmid_in_xfer: got cyc=%b want 1", s_cyc[0]); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (s_cyc[0] || s_stb[0] || s_we[0] || s_adr[0] !== 32'h0 || m_ack[0] || m_err[0] || m_rty[0] || m_rd[0] !== 32'h0) begin
      bad++;
      $display("FAIL rstmid_outputs: got cyc=%b we=%b adr=%h ack=%b err=%b rd=%h want 0",
               s_cyc[0], s_we[0], s_adr[0], m_ack[0], m_err[0], m_rd[0]);
    end
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mode[0] = 0;
    @(negedge clk);
    total++;
    if (s_cyc[0] || m_ack[0] || m_err[0] || m_rty[0]) begin
      bad++;
      $display("FAIL rstmid_idle: got cyc=%b ack=%b want 0", s_cyc[0], m_ack[0]);
    end
    run_txn(0, 32'h0000_0700, 32'h0, 4'b0100, 1'b0);
    total++; if (got_kind !== 1 || got_lat !== 2) begin bad++; $display("FAIL rstmid_recover: got kind=%0d lat=%0d want 1/2", got_kind, got_lat); end
  endtask

  task automatic test_cyc_drop();
    mode[1] = 1;
    @(negedge clk);
    m_adr = 32'h800; m_sel = 4'hF; m_we = 1'b0;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    @(posedge clk); @(negedge clk); @(negedge clk);
    total++;
    if (s_cyc[1] !== 1'b1 || s_adr[1] !== 32'h800) begin
      bad++;
      $display("FAIL drop_in_xfer: got cyc=%b adr=%h want 1/800", s_cyc[1], s_adr[1]);
    end
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (s_cyc[1] || s_stb[1] || m_ack[1] || m_err[1] || m_rty[1]) begin
        bad++;
        $display("FAIL drop_quiet%0d: got cyc=%b stb=%b ack=%b err=%b rty=%b want 0",
                 k, s_cyc[1], s_stb[1], m_ack[1], m_err[1], m_rty[1]);
      end
    end
    mode[1] = 0;
  endtask

  task automatic test_back_to_back();
    int acks, first, second;
    smem[0][8'h43] = 8'h5A;
    acks = 0; first = -1; second = -1;
    @(negedge clk);
    base_n[0] = lg_n[0];
    m_adr = 32'h40; m_sel = 4'b0001; m_we = 1'b0;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_ack[0]) begin
        acks++;
        if (acks == 1) first = i;
        if (acks == 2) begin second = i; m_cyc[0] = 1'b0; m_stb[0] = 1'b0; end
      end
    end
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    $display("b2b acks=%0d first=%0d second=%0d rd=%h", acks, first, second, m_rd[0]);
    total++; if (acks !== 2) begin bad++; $display("FAIL b2b_acks: got %0d want 2", acks); end
    total++; if (first !== 1 || second !== 4) begin bad++; $display("FAIL b2b_timing: got %0d,%0d want 1,4", first, second); end
    total++; if (m_rd[0] !== 32'h0000005A) begin bad++; $display("FAIL b2b_data: got %h want 0000005a", m_rd[0]); end
    total++; if (lg_n[0] - base_n[0] !== 2) begin bad++; $display("FAIL b2b_beats: got %0d want 2", lg_n[0] - base_n[0]); end
  endtask

  task automatic test_random(input int n);
    int d, w, nexp, kinj, kk, exp_kind, exp_n, ix;
    int eoff[4];
    logic [3:0] sel;
    logic we, hit;
    logic [31:0] adr, dat, base, exp_rd;
    logic [15:0] ed;
    logic [7:0] bidx;
    for (int t = 0; t < n; t++) begin
      d = $urandom_range(1);
      sel = 4'($urandom_range(15));
      we = 1'($urandom_range(1));
      adr = $urandom; dat = $urandom;
      ack_pct[d] = ($urandom_range(1) == 1) ? 100 : 60;
      kk = $urandom_range(9);
      err_beat[d] = (kk == 0) ? $urandom_range(3) : 99;
      rty_beat[d] = (kk == 1) ? $urandom_range(3) : 99;
      // Reference: lanes in ascending byte address, w bytes each
      w = (d == 1) ? 2 : 1;
      base = {adr[31:2], 2'b00};
      nexp = 0; exp_rd = 32'h0;
      for (int o = 0; o < 4; o += w) begin
        hit = 1'b0;
        for (int b = 0; b < w; b++) hit |= sel[3 - o - b];
        if (hit) begin
          eoff[nexp] = o;
          for (int b = 0; b < w; b++) begin
            bidx = base[7:0] + 8'(o + b);
            exp_rd[31 - 8*(o + b) -: 8] = smem[d][bidx];
          end
          nexp++;
        end
      end
      kinj = 99; kk = 1;
      if (err_beat[d] < nexp) begin kinj = err_beat[d]; kk = 2; end
      if (rty_beat[d] < nexp && rty_beat[d] < kinj) begin kinj = rty_beat[d]; kk = 3; end
      exp_kind = (kinj < nexp) ? kk : 1;
      exp_n    = (kinj < nexp) ? kinj + 1 : nexp;
      run_txn(d, adr, dat, sel, we);
      total++; if (got_kind !== exp_kind) begin bad++; $display("FAIL rnd%0d_kind: got %0d want %0d", t, got_kind, exp_kind); end
      total++; if (lg_n[d] - base_n[d] !== exp_n) begin bad++; $display("FAIL rnd%0d_beats: got %0d want %0d", t, lg_n[d] - base_n[d], exp_n); end
      for (int j = 0; j < exp_n && j < 4; j++) begin
        ix = (base_n[d] + j) % 64;
        ed = 16'h0;
        for (int b = 0; b < w; b++) ed = {ed[7:0], dat[31 - 8*(eoff[j] + b) -: 8]};
        total++;
        if (lg_adr[d][ix] !== base + 32'(eoff[j]) || lg_we[d][ix] !== we || (we && lg_dat[d][ix] !== ed)) begin
          bad++;
          $display("FAIL rnd%0d_beat%0d: got adr=%h we=%b dat=%h want adr=%h we=%b dat=%h",
                   t, j, lg_adr[d][ix], lg_we[d][ix], lg_dat[d][ix], base + 32'(eoff[j]), we, ed);
        end
      end
      if (exp_kind == 1 && !we) begin
        total++; if (got_rd !== exp_rd) begin bad++; $display("FAIL rnd%0d_rdata: got %h want %h", t, got_rd, exp_rd); end
      end
      if (ack_pct[d] == 100) begin
        total++; if (got_lat !== exp_n + 1) begin bad++; $display("FAIL rnd%0d_latency: got %0d want %0d", t, got_lat, exp_n + 1); end
      end
      @(negedge clk);
      total++;
      if (m_ack[d] || m_err[d] || m_rty[d] || s_cyc[d]) begin
        bad++;
        $display("FAIL rnd%0d_pulse: got ack=%b err=%b rty=%b cyc=%b want 0", t, m_ack[d], m_err[d], m_rty[d], s_cyc[d]);
      end
      defaults();
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0;
    m_adr = '0; m_dat = '0; m_sel = '0; m_we = 1'b0; m_cti = 3'b010; m_bte = 2'b01;
    m_cyc[0] = 1'b0; m_cyc[1] = 1'b0; m_stb[0] = 1'b0; m_stb[1] = 1'b0;
    base_n[0] = 0; base_n[1] = 0;
    defaults();
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 256; a++) smem[d][a] = 8'($urandom);
    test_reset();
    test_read_full8();
    test_write_partial8();
    test_read_sparse16();
    test_err8();
    test_priority();
    test_reset_mid_xfer();
    test_cyc_drop();
    test_back_to_back();
    test_random(60);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule

// File: doc/wb_downsize_seq.md
Name: wb_downsize_seq

Overview:
- Sequencing Wishbone width converter between a 32-bit master port and a narrow (8- or 16-bit) slave port.
- Splits each master access into one slave beat per active byte/halfword lane, in ascending address order (big-endian: sel[3] = byte offset 0).
- Gathers read data and returns a single master ack/err/rty.
- Sits between the intercon master side and narrow peripherals (UART, GPIO, flash).

Parameters:
aw, 32, address width
sdw, 8, slave data width; legal values 8 or 16
TIMEOUT, 255, slave-beat watchdog limit in cycles (used only with optional feature)

Ports:
wb_clk_i  in  1  clock
wb_rst_ni  in  1  asynchronous active-low reset
wbm_adr_i  in  aw  master address
wbm_dat_i  in  32  master write data
wbm_sel_i  in  4  master byte selects
wbm_we_i  in  1  master write enable
wbm_cyc_i  in  1  master cycle
wbm_stb_i  in  1  master strobe
wbm_cti_i  in  3  master cycle type (ignored)
wbm_bte_i  in  2  master burst type (ignored)
wbm_dat_o  out  32  assembled read data
wbm_ack_o  out  1  master ack
wbm_err_o  out  1  master error
wbm_rty_o  out  1  master retry
wbs_adr_o  out  aw  {wbm_adr_i[aw-1:2], lane byte offset}
wbs_dat_o  out  sdw  write data of current lane
wbs_sel_o  out  sdw/8  all ones during a beat
wbs_we_o  out  1  registered copy of wbm_we_i
wbs_cyc_o  out  1  slave cycle
wbs_stb_o  out  1  slave strobe
wbs_cti_o  out  3  constant 3'b000 (classic)
wbs_bte_o  out  2  constant 2'b00
wbs_dat_i  in  sdw  slave read data
wbs_ack_i  in  1  slave ack
wbs_err_i  in  1  slave error
wbs_rty_i  in  1  slave retry

Behaviour:
- Reset (async assert on wb_rst_ni low):
  - State IDLE.
  - All outputs 0; internal data register 0; pending mask 0.
  - Deassertion is synchronous to wb_clk_i.
- Lane mask:
  - sdw=8: pending = wbm_sel_i.
  - sdw=16: pending = {|sel[3:2], |sel[1:0]}.
- IDLE, on wbm_cyc_i & wbm_stb_i:
  - Latch adr, we, dat, pending.
  - Clear the data register.
  - If pending==0, go to DONE (no slave access, read data 0); else go to XFER.
- XFER:
  - wbs_cyc_o=wbs_stb_o=1.
  - Active lane = highest set pending bit, i.e. lowest address. Offsets: sdw=8 gives 0..3; sdw=16 gives 0 or 2.
  - wbs_dat_o = latched write-data lane.
  - On wbs_ack_i:
    - Store wbs_dat_i into the matching lane of the data register.
    - Clear that pending bit.
    - If pending becomes 0, go to DONE; else stay in XFER and present the next lane on the next cycle.
  - On wbs_err_i, go to ERR. On wbs_rty_i, go to RTY. Remaining lanes are dropped.
  - Priority when several are asserted together: err > rty > ack.
- DONE / ERR / RTY:
  - One cycle each, then back to IDLE.
  - Slave cyc/stb = 0.
  - wbm_ack_o (or wbm_err_o / wbm_rty_o) = 1 for exactly that cycle.
  - wbm_dat_o = data register. It holds its value until the next request is accepted.
  - The master request is not sampled in these cycles. A master keeping stb high is accepted the following IDLE cycle.
- Latency: zero-wait slave with N active lanes gives wbm_ack_o exactly N+1 cycles after IDLE samples the request.
- wbm_cyc_i drops during XFER: abort; slave cyc/stb low next cycle; go to IDLE; no master ack/err/rty.
- Master bursts: executed as consecutive classic transfers; cti/bte are not forwarded.
- Non-contiguous sel patterns (e.g. 4'b1001): legal; each set lane is accessed individually.

Optional Feature:
- Macro WB_DOWNSIZE_TIMEOUT_EN.
- Defined:
  - An 8+-bit counter restarts at every new slave beat and counts XFER cycles without ack/err/rty.
  - When the count reaches TIMEOUT, go to ERR: wbm_err_o pulses and slave cyc/stb drop.
- Undefined: no counter; XFER waits indefinitely.

Test Plan:
- sdw=8, read, sel=4'b1111, adr=0x100, zero-wait slave returning 0x11,0x22,0x33,0x44 -> slave adr 0x100..0x103 in order; wbm_dat_o=0x11223344; ack 5 cycles after request.
- sdw=8, write, sel=4'b0011, dat=0xAABBCCDD -> two beats: adr offset 2 data 0xCC, then offset 3 data 0xDD; single master ack.
- sdw=16, read, sel=4'b1001 -> beats at offsets 0 and 2; master receives both halfwords' selected bytes; 3-cycle latency.
- sdw=8, sel=4'b1111, slave err on second beat -> exactly one wbm_err_o pulse, no third beat, no ack.
- wb_rst_ni low mid-XFER and wbm_cyc_i drop mid-XFER -> outputs 0 immediately (reset) / next cycle (cyc drop), back to IDLE, no ack.
- WB_DOWNSIZE_TIMEOUT_EN, TIMEOUT=16, slave never acks -> wbm_err_o pulses 17 cycles after XFER entry.
